// File: rtl/ems_sdram_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ems_sdram_bridge                                                 |
// | Function : WISHBONE CPU-memory slave to SDRAM controller bridge. The CPU    |
// |            word address goes out to an external EMS mapper; the mapped      |
// |            SDRAM byte address comes back and is used for one SDRAM access.  |
// |            A bounded wait on the SDRAM acknowledge aborts a stuck access.   |
// | Config   : EMS_BRIDGE_WPOST_EN - when defined, writes are posted: the CPU   |
// |            is acknowledged in the MAP cycle and the SDRAM write finishes    |
// |            in the background.                                               |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module ems_sdram_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [19:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [19:1] map_adr_o,
  input  logic [31:0] map_adr_i,
  output logic        sdr_req_o,
  output logic        sdr_we_o,
  output logic [31:0] sdr_adr_o,
  output logic [15:0] sdr_dat_o,
  output logic [1:0]  sdr_be_o,
  input  logic        sdr_ack_i,
  input  logic [15:0] sdr_dat_i,
  output logic        busy_o
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAP  = 2'd1,
    REQ  = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] tmo_cnt;
  logic [7:0] cnt_inc;
  logic       accept;
  logic       map_ld;
  logic       req_done;
  logic       req_tmo;
  logic       ack_pulse;

  // The mapper sees the CPU address directly; it answers combinationally.
  assign map_adr_o = wb_adr_i;
  assign wb_ack_o  = ack_pulse;
  assign busy_o    = (state != IDLE);

  // State register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    map_ld    = 1'b0;
    req_done  = 1'b0;
    req_tmo   = 1'b0;
    ack_pulse = 1'b0;
    // Count value after this REQ cycle; the abort fires once TIMEOUT REQ
    // cycles have elapsed, so sdr_req_o is high exactly TIMEOUT cycles.
    cnt_inc   = tmo_cnt + 8'd1;
    case (state)
      IDLE: begin
        // The acknowledge is never driven in IDLE, so a held strobe after a
        // completed cycle is only taken as a new request once back here.
        if (wb_cyc_i && wb_stb_i) begin
          accept    = 1'b1;
          state_nxt = MAP;
        end
      end
      MAP: begin
        map_ld    = 1'b1;
        state_nxt = REQ;
`ifdef EMS_BRIDGE_WPOST_EN
        ack_pulse = sdr_we_o & wb_cyc_i;
`endif
      end
      REQ: begin
        // Acknowledge takes priority over a coincident timeout.
        if (sdr_ack_i) begin
          req_done = 1'b1;
        end else if (cnt_inc == TMO_LIMIT) begin
          req_tmo = 1'b1;
        end
        if (req_done || req_tmo) begin
`ifdef EMS_BRIDGE_WPOST_EN
          state_nxt = sdr_we_o ? IDLE : ACK;
`else
          state_nxt = ACK;
`endif
        end
      end
      ACK: begin
        // An abandoned cycle still finishes on SDRAM but gets no acknowledge.
        ack_pulse = wb_cyc_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, SDRAM handshake, timeout counter and read-data hold.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sdr_req_o <= 1'b0;
      sdr_we_o  <= 1'b0;
      sdr_adr_o <= 32'd0;
      sdr_dat_o <= 16'd0;
      sdr_be_o  <= 2'b00;
      wb_dat_o  <= 16'd0;
      tmo_cnt   <= 8'd0;
    end else begin
      if (accept) begin
        sdr_we_o  <= wb_we_i;
        sdr_be_o  <= wb_sel_i;
        sdr_dat_o <= wb_dat_i;
      end
      if (map_ld) begin
        sdr_adr_o <= map_adr_i;
        sdr_req_o <= 1'b1;
        tmo_cnt   <= 8'd0;
      end
      if (state == REQ) begin
        tmo_cnt <= cnt_inc;
      end
      if (req_done) begin
        sdr_req_o <= 1'b0;
        if (!sdr_we_o) begin
          wb_dat_o <= sdr_dat_i;
        end
      end else if (req_tmo) begin
        sdr_req_o <= 1'b0;
        if (!sdr_we_o) begin
          wb_dat_o <= 16'hFFFF;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ems_sdram_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_ems_sdram_bridge                                              |
// | Function : Directed self-checking bench for ems_sdram_bridge (TIMEOUT=4).   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_ems_sdram_bridge;

`ifdef EMS_BRIDGE_WPOST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [19:1] wb_adr;
  logic [15:0] wb_dat_w;
  logic [1:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [15:0] wb_dat_r;
  logic        wb_ack;
  logic [19:1] map_adr_o;
  logic [31:0] map_adr_i;
  logic        sdr_req;
  logic        sdr_we;
  logic [31:0] sdr_adr;
  logic [15:0] sdr_dat_w;
  logic [1:0]  sdr_be;
  logic        sdr_ack;
  logic [15:0] sdr_dat_r;
  logic        busy;

  int tests;
  int failed;

  ems_sdram_bridge #(.TIMEOUT(4)) u_dut (
    .wb_clk    (clk),
    .wb_rst_n  (rst_n),
    .wb_adr_i  (wb_adr),
    .wb_dat_i  (wb_dat_w),
    .wb_sel_i  (wb_sel),
    .wb_cyc_i  (wb_cyc),
    .wb_stb_i  (wb_stb),
    .wb_we_i   (wb_we),
    .wb_dat_o  (wb_dat_r),
    .wb_ack_o  (wb_ack),
    .map_adr_o (map_adr_o),
    .map_adr_i (map_adr_i),
    .sdr_req_o (sdr_req),
    .sdr_we_o  (sdr_we),
    .sdr_adr_o (sdr_adr),
    .sdr_dat_o (sdr_dat_w),
    .sdr_be_o  (sdr_be),
    .sdr_ack_i (sdr_ack),
    .sdr_dat_i (sdr_dat_r),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run-time guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive point just after the rising edge; sample point on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic start(input logic we, input logic [19:1] adr, input logic [31:0] map,
                       input logic [15:0] dat, input logic [1:0] sel);
    wb_cyc    = 1'b1;
    wb_stb    = 1'b1;
    wb_we     = we;
    wb_adr    = adr;
    map_adr_i = map;
    wb_dat_w  = dat;
    wb_sel    = sel;
  endtask

  task automatic release_bus();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  int req_cycles;
  int ack_cycle;
  int ack_count;
  logic [15:0] ack_dat;

  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    map_adr_i = '0; sdr_ack = 1'b0; sdr_dat_r = '0;

    // Reset state.
    sample(); sample();
    check("rst_ack",  {31'd0, wb_ack},  32'd0);
    check("rst_req",  {31'd0, sdr_req}, 32'd0);
    check("rst_we",   {31'd0, sdr_we},  32'd0);
    check("rst_adr",  sdr_adr,          32'd0);
    check("rst_sdat", {16'd0, sdr_dat_w}, 32'd0);
    check("rst_be",   {30'd0, sdr_be},  32'd0);
    check("rst_wdat", {16'd0, wb_dat_r}, 32'd0);
    check("rst_busy", {31'd0, busy},    32'd0);
    tick(); rst_n = 1'b1;

    // Read, ack three cycles after req (coincides with the TIMEOUT=4 limit).
    tick(); start(1'b0, 19'h12345, 32'h0002468A, 16'h0000, 2'b11);
    sample();
    check("rd_mapadr", {13'd0, map_adr_o}, 32'h00012345);
    check("rd_c0_busy", {31'd0, busy}, 32'd0);
    tick(); sample();
    check("rd_c1_busy", {31'd0, busy}, 32'd1);
    check("rd_c1_req",  {31'd0, sdr_req}, 32'd0);
    tick(); sample();
    check("rd_c2_req", {31'd0, sdr_req}, 32'd1);
    check("rd_c2_adr", sdr_adr, 32'h0002468A);
    check("rd_c2_we",  {31'd0, sdr_we}, 32'd0);
    tick(); sample();
    tick(); sample();
    check("rd_c4_req", {31'd0, sdr_req}, 32'd1);
    tick(); sdr_ack = 1'b1; sdr_dat_r = 16'hBEEF; sample();
    check("rd_c5_ack", {31'd0, wb_ack}, 32'd0);
    tick(); sdr_ack = 1'b0; sdr_dat_r = 16'h0000; sample();
    check("rd_c6_ack", {31'd0, wb_ack}, 32'd1);
    check("rd_c6_dat", {16'd0, wb_dat_r}, 32'h0000BEEF);
    check("rd_c6_req", {31'd0, sdr_req}, 32'd0);
    tick(); release_bus(); sample();
    check("rd_c7_ack",  {31'd0, wb_ack}, 32'd0);
    check("rd_c7_busy", {31'd0, busy}, 32'd0);

    // Write through EMS page frame.
    tick(); start(1'b1, 19'h0C000, 32'h00814000, 16'hA55A, 2'b01); sample();
    tick(); sample();
    check("wr_c1_ack", {31'd0, wb_ack}, {31'd0, POSTED});
    tick(); if (POSTED) release_bus(); sample();
    check("wr_c2_req", {31'd0, sdr_req}, 32'd1);
    check("wr_c2_we",  {31'd0, sdr_we}, 32'd1);
    check("wr_c2_be",  {30'd0, sdr_be}, 32'd1);
    check("wr_c2_dat", {16'd0, sdr_dat_w}, 32'h0000A55A);
    check("wr_c2_adr", sdr_adr, 32'h00814000);
    check("wr_c2_ack", {31'd0, wb_ack}, 32'd0);
    tick(); sdr_ack = 1'b1; sample();
    check("wr_c3_ack", {31'd0, wb_ack}, 32'd0);
    tick(); sdr_ack = 1'b0; sample();
    check("wr_c4_ack",  {31'd0, wb_ack}, {31'd0, !POSTED});
    check("wr_c4_req",  {31'd0, sdr_req}, 32'd0);
    check("wr_c4_busy", {31'd0, busy}, {31'd0, !POSTED});
    check("wr_rdhold",  {16'd0, wb_dat_r}, 32'h0000BEEF);
    tick(); release_bus(); sample();
    check("wr_c5_busy", {31'd0, busy}, 32'd0);

    // Timeout: no SDRAM acknowledge at all.
    tick(); start(1'b0, 19'h00010, 32'h00000020, 16'h0000, 2'b11); sample();
    req_cycles = 0; ack_cycle = -1; ack_count = 0; ack_dat = '0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (ack_count != 0) release_bus();
      sample();
      if (sdr_req) req_cycles++;
      if (wb_ack) begin
        ack_count++;
        ack_cycle = i;
        ack_dat = wb_dat_r;
      end
    end
    check("tmo_req_cycles", req_cycles, 32'd4);
    check("tmo_ack_cycle",  ack_cycle,  32'd6);
    check("tmo_ack_count",  ack_count,  32'd1);
    check("tmo_dat",        {16'd0, ack_dat}, 32'h0000FFFF);
    check("tmo_busy",       {31'd0, busy}, 32'd0);

    // Abandoned cycle: CPU drops cyc while the SDRAM request is pending.
    tick(); start(1'b0, 19'h00200, 32'h00000400, 16'h0000, 2'b11); sample();
    tick(); sample();
    tick(); sample();
    check("ab_c2_req", {31'd0, sdr_req}, 32'd1);
    tick(); release_bus(); sample();
    check("ab_c3_req", {31'd0, sdr_req}, 32'd1);
    tick(); sample();
    check("ab_c4_req", {31'd0, sdr_req}, 32'd1);
    tick(); sdr_ack = 1'b1; sdr_dat_r = 16'h1234; sample();
    tick(); sdr_ack = 1'b0; sample();
    check("ab_c6_ack",  {31'd0, wb_ack}, 32'd0);
    check("ab_c6_req",  {31'd0, sdr_req}, 32'd0);
    tick(); sample();
    check("ab_c7_ack",  {31'd0, wb_ack}, 32'd0);
    check("ab_c7_busy", {31'd0, busy}, 32'd0);

    // Reset during REQ, then a stray acknowledge after release.
    tick(); start(1'b0, 19'h00300, 32'h00000600, 16'h0000, 2'b11); sample();
    tick(); sample();
    tick(); sample();
    check("rr_c2_req", {31'd0, sdr_req}, 32'd1);
    tick(); rst_n = 1'b0; release_bus(); #1;
    check("rr_req_async",  {31'd0, sdr_req}, 32'd0);
    check("rr_busy_async", {31'd0, busy}, 32'd0);
    tick(); rst_n = 1'b1;
    tick(); sdr_ack = 1'b1; sdr_dat_r = 16'h5678; sample();
    check("rr_stray_ack", {31'd0, wb_ack}, 32'd0);
    tick(); sdr_ack = 1'b0; sample();
    check("rr_post_ack",  {31'd0, wb_ack}, 32'd0);
    check("rr_post_busy", {31'd0, busy}, 32'd0);
    check("rr_post_req",  {31'd0, sdr_req}, 32'd0);
    check("rr_post_dat",  {16'd0, wb_dat_r}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
